// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared RV32I datapath (addi, bne, lw).
// Define MULTICYCLE_CTRL_PERF_EN to build the cycle and retire counters.
module multicycle_ctrl #(
  parameter int unsigned IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] instr,
  input  logic                eq,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_we,
  output logic                pc_we,
  output logic                RegWrite,
  output logic [2:0]          ALUctrl,
  output logic                ALUsrc,
  output logic [1:0]          ImmSrc,
  output logic                PCsrc,
  output logic                data_src,
  output logic                illegal,
  output logic [31:0]         cyc_cnt,
  output logic [31:0]         ret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    OP_ADDI, OP_BNE, OP_LW
  } op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;

  // Only the major opcode field is decoded.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[IN_WIDTH-1:7], instr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADDI;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    RegWrite = 1'b0;
    ALUctrl  = 3'b000;
    ALUsrc   = 1'b0;
    ImmSrc   = 2'b00;
    PCsrc    = 1'b0;
    data_src = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Opcode class is latched so EXEC does not depend on IR staying put.
        case (instr[6:2])
          5'b00100: begin op_d = OP_ADDI; state_d = S_EXEC; end
          5'b11000: begin op_d = OP_BNE;  state_d = S_EXEC; end
          5'b00000: begin op_d = OP_LW;   state_d = S_EXEC; end
          default:  state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_ADDI: begin
            ALUsrc   = 1'b1;
            RegWrite = 1'b1;
            pc_we    = 1'b1;
            state_d  = S_FETCH;
          end
          OP_BNE: begin
            ALUctrl = 3'b001;
            ImmSrc  = 2'b10;
            pc_we   = 1'b1;
            PCsrc   = ~eq;
            state_d = S_FETCH;
          end
          OP_LW: begin
            ALUsrc  = 1'b1;
            state_d = S_MEM;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        ALUsrc   = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ready) state_d = S_WB;
      end
      S_WB: begin
        RegWrite = 1'b1;
        data_src = 1'b1;
        pc_we    = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, ret_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else if (state_q != S_TRAP) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (pc_we) ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-cycle expected outputs are built
// from instruction-level timing rules and compared against the DUT.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_we;
    logic       pc_we;
    logic       RegWrite;
    logic [2:0] ALUctrl;
    logic       ALUsrc;
    logic [1:0] ImmSrc;
    logic       PCsrc;
    logic       data_src;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic        ir;
    logic        dr;
    logic        eqv;
    logic [31:0] iv;
    outs_t       exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        eq = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, dmem_req, ir_we, pc_we, RegWrite, ALUsrc, PCsrc, data_src, illegal;
  logic [2:0]  ALUctrl;
  logic [1:0]  ImmSrc;
  logic [31:0] cyc_cnt, ret_cnt;

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc_m = 0, ret_m = 0;
  int unsigned dreq_seen = 0, run_cycles = 0, first_pcwe = 0;
  cyc_t q[$];

  multicycle_ctrl #(.IN_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we),
    .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .PCsrc(PCsrc), .data_src(data_src), .illegal(illegal),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  function automatic outs_t observed();
    return {imem_req, dmem_req, ir_we, pc_we, RegWrite, ALUctrl, ALUsrc, ImmSrc,
            PCsrc, data_src, illegal};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic ir, input logic dr, input logic eqv,
                      input logic [31:0] iv, input outs_t e);
    cyc_t c;
    c.ir = ir; c.dr = dr; c.eqv = eqv; c.iv = iv; c.exp = e;
    q.push_back(c);
  endtask

  // Expected trace of one instruction, from fetch up to its last cycle.
  task automatic build_instr(input logic [31:0] ins, input int unsigned iw,
                             input int unsigned dw, input logic eqv);
    outs_t e;
    for (int unsigned i = 0; i < iw; i++) begin
      e = '0; e.imem_req = 1'b1;
      push(1'b0, rb(), rb(), $urandom, e);
    end
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
    push(1'b1, rb(), rb(), $urandom, e);
    e = '0;
    push(rb(), rb(), rb(), ins, e);
    case (ins[6:2])
      5'b00100: begin
        e = '0; e.ALUsrc = 1'b1; e.RegWrite = 1'b1; e.pc_we = 1'b1;
        push(rb(), rb(), rb(), ins, e);
      end
      5'b11000: begin
        e = '0; e.ALUctrl = 3'b001; e.ImmSrc = 2'b10; e.pc_we = 1'b1; e.PCsrc = ~eqv;
        push(rb(), rb(), eqv, ins, e);
      end
      5'b00000: begin
        e = '0; e.ALUsrc = 1'b1;
        push(rb(), rb(), rb(), ins, e);
        e.dmem_req = 1'b1;
        for (int unsigned i = 0; i < dw; i++) push(rb(), 1'b0, rb(), ins, e);
        push(rb(), 1'b1, rb(), ins, e);
        e = '0; e.RegWrite = 1'b1; e.data_src = 1'b1; e.pc_we = 1'b1;
        push(rb(), rb(), rb(), ins, e);
      end
      default: ;
    endcase
  endtask

  task automatic run_queue(input int unsigned max_n);
    cyc_t c;
    outs_t o;
    logic [31:0] ec, er;
    int unsigned n = 0;
    dreq_seen = 0; run_cycles = 0; first_pcwe = 0;
    while (q.size() > 0 && n < max_n) begin
      c = q.pop_front();
      n++;
      @(negedge clk);
      imem_ready = c.ir; dmem_ready = c.dr; eq = c.eqv; instr = c.iv;
      #1;
      o = observed();
      run_cycles++;
      if (o.dmem_req) dreq_seen++;
      if (o.pc_we && first_pcwe == 0) first_pcwe = run_cycles;
      n_cmp++;
      if (o !== c.exp) begin
        n_err++;
        $display("FAIL outs cyc=%0d got=%b exp=%b", cyc_m, o, c.exp);
      end
`ifdef MULTICYCLE_CTRL_PERF_EN
      ec = cyc_m; er = ret_m;
`else
      ec = '0; er = '0;
`endif
      n_cmp++;
      if (cyc_cnt !== ec || ret_cnt !== er) begin
        n_err++;
        $display("FAIL counters got=%h/%h exp=%h/%h", cyc_cnt, ret_cnt, ec, er);
      end
      if (!c.exp.illegal) cyc_m++;
      if (c.exp.pc_we) ret_m++;
    end
    q.delete();
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (observed() !== '0 || cyc_cnt !== '0 || ret_cnt !== '0) begin
      n_err++;
      $display("FAIL %s got=%b cnt=%h/%h exp=all zero", name, observed(), cyc_cnt, ret_cnt);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = rb(); dmem_ready = rb();
    #1;
    check_zero("idle");
    cyc_m = 1; ret_m = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1; eq = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    release_reset();
  endtask

  task automatic test_addi();
    build_instr(32'h0050_0093, 0, 0, 1'b0);
    build_instr(32'h0050_0093, 0, 0, 1'b0);
    run_queue(100);
    n_cmp++;
    if (first_pcwe != 3) begin
      n_err++;
      $display("FAIL addi_latency got=%0d exp=3", first_pcwe);
    end
  endtask

  task automatic test_bne();
    build_instr(32'hFE20_9EE3, 0, 0, 1'b0);
    build_instr(32'hFE20_9EE3, 1, 0, 1'b1);
    run_queue(100);
  endtask

  task automatic test_lw();
    build_instr(32'h0000_A103, 0, 3, 1'b0);
    run_queue(100);
    n_cmp++;
    if (dreq_seen != 4 || first_pcwe != 8) begin
      n_err++;
      $display("FAIL lw_timing dmem_req_cycles=%0d latency=%0d exp=4/8", dreq_seen, first_pcwe);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [4:0]  ops [3];
    ops[0] = 5'b00100; ops[1] = 5'b11000; ops[2] = 5'b00000;
    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      ins[6:2] = ops[$urandom_range(0, 2)];
      ins[1:0] = 2'b11;
      build_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end
    run_queue(1000);
  endtask

  task automatic test_trap();
    outs_t e;
    logic [31:0] ins;
    int unsigned pcwe_cnt = 0;
    ins = $urandom;
    ins[6:2] = 5'b11111;
    ins[1:0] = 2'b11;
    build_instr(ins, 1, 0, 1'b0);
    e = '0; e.illegal = 1'b1;
    for (int i = 0; i < 22; i++) push(rb(), rb(), rb(), $urandom, e);
    run_queue(100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (pc_we || imem_req || RegWrite || !illegal) pcwe_cnt++;
    end
    n_cmp++;
    if (pcwe_cnt != 0) begin
      n_err++;
      $display("FAIL trap_hold bad_cycles=%0d exp=0", pcwe_cnt);
    end
    rst_n = 1'b0;
    #1;
    check_zero("trap_reset");
    release_reset();
  endtask

  task automatic test_reset_mid_mem();
    outs_t e;
    build_instr(32'h0000_A103, 0, 6, 1'b0);
    run_queue(5);
    n_cmp++;
    if (dmem_req !== 1'b1) begin
      n_err++;
      $display("FAIL mid_mem_setup dmem_req=%b exp=1", dmem_req);
    end
    #1;
    rst_n = 1'b0;
    dmem_ready = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk); #1;
    check_zero("reset_hold");
    release_reset();
    e = '0; e.imem_req = 1'b1;
    push(1'b0, 1'b1, 1'b0, $urandom, e);
    run_queue(1);
    build_instr(32'h0050_0093, 0, 0, 1'b0);
    run_queue(100);
  endtask

  task automatic test_wrap();
`ifdef MULTICYCLE_CTRL_PERF_EN
    @(negedge clk);
    imem_ready = 1'b0;
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
    @(negedge clk); #1;
    n_cmp++;
    if (cyc_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL cyc_wrap got=%h exp=00000000", cyc_cnt);
    end
    rst_n = 1'b0;
    #1;
    release_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bne();
    test_lw();
    test_back_to_back();
    test_reset_mid_mem();
    test_wrap();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
